otbn_mod_addsub_vec: RTL and testbench

Pipelined, multi-lane modular adder/subtractor for the post-quantum vector datapath. It computes (a + b) mod q or (a − b) mod q on NUM_LANES independent lanes of DATA_WIDTH bits each, with one modulus shared by all lanes. Operation uses an extended-width intermediate, so it is correct for any q up to 2^DATA_WIDTH − 1. The block sits between the vector register read stage and writeback, and uses a valid/ready handshake on both sides.

---
 rtl/otbn_mod_addsub_vec_pkg.sv | 14 +
 rtl/otbn_mod_addsub_vec_if.sv | 29 ++
 rtl/otbn_mod_addsub_vec_lane.sv | 41 ++++
 rtl/otbn_mod_addsub_vec.sv | 99 +++++++++
 tb/tb_otbn_mod_addsub_vec.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/otbn_mod_addsub_vec_pkg.sv
// Shared types and helpers for the vector modular adder/subtractor.
package otbn_mod_pkg;

    typedef enum logic {
        ModAdd = 1'b0,
        ModSub = 1'b1
    } mod_op_e;

    // Bit offset of lane 'lane' in a vector packed as lanes of 'width' bits.
    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
        return lane * width;
    endfunction

endpackage

// File: rtl/otbn_mod_addsub_vec_if.sv
// Request/response bundle of the modular add/sub block (valid/ready both sides).
interface otbn_mod_addsub_vec_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_LANES  = 8
);
    localparam int unsigned VEC_WIDTH = NUM_LANES * DATA_WIDTH;

    logic                  in_valid_i;
    logic                  in_ready_o;
    logic                  mode_i;
    logic [VEC_WIDTH-1:0]  op0_i;
    logic [VEC_WIDTH-1:0]  op1_i;
    logic [DATA_WIDTH-1:0] q_i;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [VEC_WIDTH-1:0]  res_o;
    logic                  err_o;

    modport master (
        output in_valid_i, mode_i, op0_i, op1_i, q_i, out_ready_i,
        input  in_ready_o, out_valid_o, res_o, err_o
    );

    modport slave (
        input  in_valid_i, mode_i, op0_i, op1_i, q_i, out_ready_i,
        output in_ready_o, out_valid_o, res_o, err_o
    );

endinterface

// File: rtl/otbn_mod_addsub_vec_lane.sv
// Combinational logic of one lane: stage-1 intermediate and range check,
// stage-2 conditional subtract of the modulus.
module otbn_mod_lane
    import otbn_mod_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  mod_op_e               mode,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [DATA_WIDTH-1:0] q,
    output logic [DATA_WIDTH:0]   t,
    output logic                  range_err,
    input  logic [DATA_WIDTH:0]   t_reg,
    input  logic [DATA_WIDTH-1:0] q_reg,
    output logic [DATA_WIDTH-1:0] res
);

    // Stage 1: one-bit-wider sum (add) or a + q - b (sub) so nothing wraps for in-range operands.
    always_comb begin
        t = '0;
        case (mode)
            ModAdd:  t = {1'b0, a} + {1'b0, b};
            ModSub:  t = {1'b0, a} + {1'b0, q} - {1'b0, b};
            default: t = '0;
        endcase
    end

    assign range_err = (a >= q) | (b >= q);

    // Stage 2: subtract q once if the intermediate reached it; low bits of t - q equal the truncated result.
    always_comb begin
        res = t_reg[DATA_WIDTH-1:0];
        if (t_reg >= {1'b0, q_reg}) begin
            res = t_reg[DATA_WIDTH-1:0] - q_reg;
        end else begin
            res = t_reg[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/otbn_mod_addsub_vec.sv
// Two-stage pipelined multi-lane modular adder/subtractor with a shared modulus.
// Ready propagates combinationally back through both stages.
module otbn_mod_addsub_vec
    import otbn_mod_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_LANES  = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    otbn_mod_addsub_vec_if.slave   bus
);

    localparam int unsigned VEC_WIDTH = NUM_LANES * DATA_WIDTH;

    mod_op_e                               mode_s;
    logic [NUM_LANES-1:0][DATA_WIDTH:0]    t_s;
    logic [NUM_LANES-1:0]                  lane_err_s;
    logic [VEC_WIDTH-1:0]                  res_s;
    logic                                  s1_en_s;
    logic                                  s2_en_s;
    logic                                  in_ready_s;

    logic                                  s1_v_r;
    logic [NUM_LANES-1:0][DATA_WIDTH:0]    s1_t_r;
    logic [DATA_WIDTH-1:0]                 s1_q_r;
    logic                                  s1_err_r;
    logic                                  s2_v_r;
    logic [VEC_WIDTH-1:0]                  s2_res_r;
    logic                                  s2_err_r;

    assign mode_s = mod_op_e'(bus.mode_i);

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        localparam int unsigned Lsb = lane_lsb(i, DATA_WIDTH);

        otbn_mod_lane #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_lane (
            .mode      (mode_s),
            .a         (bus.op0_i[Lsb +: DATA_WIDTH]),
            .b         (bus.op1_i[Lsb +: DATA_WIDTH]),
            .q         (bus.q_i),
            .t         (t_s[i]),
            .range_err (lane_err_s[i]),
            .t_reg     (s1_t_r[i]),
            .q_reg     (s1_q_r),
            .res       (res_s[Lsb +: DATA_WIDTH])
        );
    end

    // Stage enables: a stage may load when empty or when the stage after it drains.
    always_comb begin
        s2_en_s    = 1'b0;
        s1_en_s    = 1'b0;
        in_ready_s = 1'b0;
        s2_en_s    = !s2_v_r || bus.out_ready_i;
        s1_en_s    = !s1_v_r || s2_en_s;
        in_ready_s = s1_en_s && !rst_i;
    end

    // Stage 1: capture per-lane intermediates, modulus and the range-error flag on an input transfer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_v_r   <= 1'b0;
            s1_t_r   <= '0;
            s1_q_r   <= '0;
            s1_err_r <= 1'b0;
        end else if (s1_en_s) begin
            s1_v_r <= bus.in_valid_i;
            if (bus.in_valid_i) begin
                s1_t_r   <= t_s;
                s1_q_r   <= bus.q_i;
                s1_err_r <= |lane_err_s;
            end
        end
    end

    // Stage 2: capture reduced results; held while the consumer stalls.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s2_v_r   <= 1'b0;
            s2_res_r <= '0;
            s2_err_r <= 1'b0;
        end else if (s2_en_s) begin
            s2_v_r <= s1_v_r;
            if (s1_v_r) begin
                s2_res_r <= res_s;
                s2_err_r <= s1_err_r;
            end
        end
    end

    assign bus.in_ready_o  = in_ready_s;
    assign bus.out_valid_o = s2_v_r;
    assign bus.res_o       = s2_res_r;
    assign bus.err_o       = s2_err_r;

endmodule

// File: tb/tb_otbn_mod_addsub_vec.sv
// Scoreboard bench for otbn_mod_addsub_vec: stimulus pushes reference results,
// an independent monitor pops and compares on each output transfer.
module tb_otbn_mod_addsub_vec;

    localparam int DW = 32;
    localparam int NL = 8;
    localparam int VW = DW * NL;
    localparam logic [DW-1:0] Q_KYBER = 32'd3329;
    localparam logic [DW-1:0] Q_DIL   = 32'd8380417;
    localparam logic [DW-1:0] Q_FULL  = 32'hFFFFFFFB;

    typedef struct {
        logic [VW-1:0] res;
        logic          err;
        int            cyc;
        bit            lat;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   pass_cnt;
    int   total_cnt;
    int   accepted;
    exp_t sb[$];
    int   out_cyc_q[$];

    otbn_mod_addsub_vec_if #(.DATA_WIDTH(DW), .NUM_LANES(NL)) bus ();

    otbn_mod_addsub_vec #(.DATA_WIDTH(DW), .NUM_LANES(NL)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic chk(input bit ok, input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        total_cnt++;
        if (ok) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference: exact modular arithmetic for in-range lanes, the literal formula otherwise.
    function automatic exp_t model(input logic mode, input logic [VW-1:0] op0, input logic [VW-1:0] op1,
                                   input logic [DW-1:0] q);
        exp_t   e;
        longint a, b, qq, t, r;
        e.res = '0;
        e.err = 1'b0;
        e.cyc = 0;
        e.lat = 1'b0;
        qq = {32'd0, q};
        for (int l = 0; l < NL; l++) begin
            a = {32'd0, op0[l*DW +: DW]};
            b = {32'd0, op1[l*DW +: DW]};
            if (a >= qq || b >= qq) begin
                e.err = 1'b1;
                t = (mode == 1'b0) ? (a + b) : ((a + qq - b) & 64'h1_FFFF_FFFF);
                r = (t >= qq) ? (t - qq) : t;
            end else if (mode == 1'b0) begin
                r = (a + b) % qq;
            end else begin
                r = ((a - b) % qq + qq) % qq;
            end
            e.res[l*DW +: DW] = r[DW-1:0];
        end
        return e;
    endfunction

    function automatic logic [VW-1:0] splat(input logic [DW-1:0] x);
        logic [VW-1:0] v;
        for (int l = 0; l < NL; l++) v[l*DW +: DW] = x;
        return v;
    endfunction

    function automatic logic [VW-1:0] rand_vec(input logic [DW-1:0] q);
        logic [VW-1:0] v;
        for (int l = 0; l < NL; l++) v[l*DW +: DW] = $urandom_range(0, q - 1);
        return v;
    endfunction

    // Offer one transaction (called at posedge+1); returns at posedge+1 after acceptance.
    task automatic send(input logic mode, input logic [VW-1:0] op0, input logic [VW-1:0] op1,
                        input logic [DW-1:0] q, input bit lat);
        exp_t e;
        bit   done;
        done = 1'b0;
        bus.in_valid_i = 1'b1;
        bus.mode_i     = mode;
        bus.op0_i      = op0;
        bus.op1_i      = op1;
        bus.q_i        = q;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.in_ready_o) begin
                e     = model(mode, op0, op1, q);
                e.cyc = cyc + 1;
                e.lat = lat;
                sb.push_back(e);
                accepted++;
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            if (done) break;
        end
        bus.in_valid_i = 1'b0;
        bus.op0_i      = '0;
        bus.op1_i      = '0;
        if (!done) chk(1'b0, "accept_timeout", '0, 1);
    endtask

    task automatic drain();
        for (int k = 0; k < 200; k++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
        end
        #1;
        chk(sb.size() == 0, "drain", sb.size(), 0);
    endtask

    // Monitor: every output transfer must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.out_valid_o && bus.out_ready_i) begin
                out_cyc_q.push_back(cyc + 1);
                if (sb.size() == 0) begin
                    chk(1'b0, "unexpected_output", bus.res_o, '0);
                end else begin
                    e = sb.pop_front();
                    chk(bus.res_o === e.res, "result", bus.res_o, e.res);
                    chk(bus.err_o === e.err, "err", bus.err_o, e.err);
                    if (e.lat) chk((cyc + 1 - e.cyc) == 2, "latency", cyc + 1 - e.cyc, 2);
                end
            end
        end
    end

    initial begin
        logic [VW-1:0] held;
        logic [VW-1:0] v0;
        pass_cnt = 0;
        total_cnt = 0;
        accepted = 0;
        rst = 1'b1;
        bus.in_valid_i  = 1'b0;
        bus.mode_i      = 1'b0;
        bus.op0_i       = '0;
        bus.op1_i       = '0;
        bus.q_i         = '0;
        bus.out_ready_i = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk(bus.in_ready_o == 1'b0, "in_ready_in_reset", bus.in_ready_o, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk(bus.out_valid_o == 1'b0, "rst_out_valid", bus.out_valid_o, 0);
        chk(bus.res_o == '0, "rst_res", bus.res_o, 0);
        chk(bus.err_o == 1'b0, "rst_err", bus.err_o, 0);
        chk(bus.in_ready_o == 1'b1, "in_ready_after_rst", bus.in_ready_o, 1);
        @(posedge clk);
        #1;

        // Kyber directed vectors and full-width corner cases
        send(1'b0, splat(32'd3000), splat(32'd1000), Q_KYBER, 1'b1);
        send(1'b0, splat(32'd3328), splat(32'd3328), Q_KYBER, 1'b1);
        send(1'b1, splat(32'd5),    splat(32'd10),   Q_KYBER, 1'b1);
        send(1'b1, splat(32'd7),    splat(32'd7),    Q_KYBER, 1'b1);
        send(1'b0, splat(32'hFFFFFFFA), splat(32'hFFFFFFFA), Q_FULL, 1'b1);
        send(1'b1, splat(32'd0),        splat(32'hFFFFFFFA), Q_FULL, 1'b1);
        drain();

        // Back-to-back random Dilithium stream
        for (int n = 0; n < 16; n++)
            send(1'($urandom_range(0, 1)), rand_vec(Q_DIL), rand_vec(Q_DIL), Q_DIL, 1'b1);
        drain();

        // Backpressure: 4 offered with the consumer stalled
        bus.out_ready_i = 1'b0;
        accepted = 0;
        fork
            begin
                for (int n = 0; n < 4; n++)
                    send(1'($urandom_range(0, 1)), rand_vec(Q_KYBER), rand_vec(Q_KYBER), Q_KYBER, 1'b0);
            end
            begin
                repeat (6) @(negedge clk);
                chk(accepted == 2, "bp_accepted", accepted, 2);
                chk(bus.in_ready_o == 1'b0, "bp_in_ready", bus.in_ready_o, 0);
                chk(bus.out_valid_o == 1'b1, "bp_out_valid", bus.out_valid_o, 1);
                held = bus.res_o;
                repeat (3) begin
                    @(negedge clk);
                    chk(bus.res_o == held, "bp_res_stable", bus.res_o, held);
                end
                out_cyc_q.delete();
                @(posedge clk);
                #1 bus.out_ready_i = 1'b1;
            end
        join
        drain();
        chk(out_cyc_q.size() == 4, "bp_out_count", out_cyc_q.size(), 4);
        if (out_cyc_q.size() == 4)
            chk(out_cyc_q[3] - out_cyc_q[0] == 3, "bp_no_gaps", out_cyc_q[3] - out_cyc_q[0], 3);

        // Range error on lane 3 only, then a clean transaction
        v0 = rand_vec(Q_KYBER);
        v0[3*DW +: DW] = Q_KYBER;
        send(1'b0, v0, rand_vec(Q_KYBER), Q_KYBER, 1'b1);
        send(1'b1, rand_vec(Q_KYBER), rand_vec(Q_KYBER), Q_KYBER, 1'b1);
        drain();

        // Reset with two transactions in flight
        bus.out_ready_i = 1'b0;
        send(1'b0, rand_vec(Q_KYBER), rand_vec(Q_KYBER), Q_KYBER, 1'b0);
        send(1'b1, rand_vec(Q_KYBER), rand_vec(Q_KYBER), Q_KYBER, 1'b0);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        chk(bus.in_ready_o == 1'b0, "mid_rst_in_ready", bus.in_ready_o, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk(bus.out_valid_o == 1'b0, "mid_rst_out_valid", bus.out_valid_o, 0);
        chk(bus.res_o == '0, "mid_rst_res", bus.res_o, 0);
        chk(bus.err_o == 1'b0, "mid_rst_err", bus.err_o, 0);
        @(posedge clk);
        #1 bus.out_ready_i = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        send(1'b0, rand_vec(Q_DIL), rand_vec(Q_DIL), Q_DIL, 1'b1);
        drain();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
